// File: rtl/srbank_arbiter.sv
// rtl/srbank_arbiter.sv - two-requester round-robin sequencer owning a WIDTH-bit SR storage bank
// Converts D/T/JK/SR operations into per-bit set/reset drives and applies them one transaction at a time.
module srbank_arbiter #(
   parameter int WIDTH = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             req0,
   input  logic [1:0]       op0,
   input  logic [WIDTH-1:0] a0,
   input  logic [WIDTH-1:0] b0,
   output logic             ack0,
   input  logic             req1,
   input  logic [1:0]       op1,
   input  logic [WIDTH-1:0] a1,
   input  logic [WIDTH-1:0] b1,
   output logic             ack1,
   output logic [WIDTH-1:0] q,
   output logic             busy,
   output logic             err,
   input  logic             err_clr,
   output logic             last_grant
);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_APPLY = 2'd1,
      S_ACK   = 2'd2
   } state_t;

   localparam logic [1:0] OP_D  = 2'b00;
   localparam logic [1:0] OP_T  = 2'b01;
   localparam logic [1:0] OP_JK = 2'b10;
   localparam logic [1:0] OP_SR = 2'b11;

   state_t           state_q, state_d;
   logic [1:0]       op_q, op_d;
   logic [WIDTH-1:0] a_q, a_d;
   logic [WIDTH-1:0] b_q, b_d;
   logic [WIDTH-1:0] q_q, q_d;
   logic             gnt_q, gnt_d;
   logic             last_grant_q, last_grant_d;
   logic             busy_q, busy_d;
   logic             err_q, err_d;
   logic             ack0_q, ack0_d;
   logic             ack1_q, ack1_d;

   logic [WIDTH-1:0] s_vec;
   logic [WIDTH-1:0] r_vec;
   logic             pick;
   logic             err_set;

   // Per-bit set/reset drives derived from the latched operation and the current bank.
   always_comb begin
      s_vec = '0;
      r_vec = '0;
      case (op_q)
         OP_D: begin
            s_vec = a_q;
            r_vec = ~a_q;
         end
         OP_T: begin
            s_vec = a_q & ~q_q;
            r_vec = a_q & q_q;
         end
         OP_JK: begin
            s_vec = a_q & ~q_q;
            r_vec = b_q & q_q;
         end
         OP_SR: begin
            s_vec = a_q;
            r_vec = b_q;
         end
         default: begin
            s_vec = '0;
            r_vec = '0;
         end
      endcase
   end

   always_comb begin
      state_d      = state_q;
      op_d         = op_q;
      a_d          = a_q;
      b_d          = b_q;
      q_d          = q_q;
      gnt_d        = gnt_q;
      last_grant_d = last_grant_q;
      busy_d       = busy_q;
      ack0_d       = 1'b0;
      ack1_d       = 1'b0;
      err_set      = 1'b0;
      pick         = 1'b0;

      case (state_q)
         S_IDLE: begin
            busy_d = 1'b0;
            if (req0 || req1) begin
               pick         = (req0 && req1) ? ~last_grant_q : req1;
               gnt_d        = pick;
               last_grant_d = pick;
               op_d         = pick ? op1 : op0;
               a_d          = pick ? a1  : a0;
               b_d          = pick ? b1  : b0;
               busy_d       = 1'b1;
               state_d      = S_APPLY;
            end
         end
         S_APPLY: begin
            // S=R=1 falls into the hold term, so a conflicting bit keeps its value.
            q_d     = (q_q & ~(r_vec & ~s_vec)) | (s_vec & ~r_vec);
            err_set = (op_q == OP_SR) && |(a_q & b_q);
            state_d = S_ACK;
         end
         S_ACK: begin
            ack0_d  = ~gnt_q;
            ack1_d  = gnt_q;
            busy_d  = 1'b0;
            state_d = S_IDLE;
         end
         default: begin
            busy_d  = 1'b0;
            state_d = S_IDLE;
         end
      endcase

      err_d = (err_q && !err_clr) || err_set;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= S_IDLE;
         op_q         <= '0;
         a_q          <= '0;
         b_q          <= '0;
         q_q          <= '0;
         gnt_q        <= 1'b0;
         last_grant_q <= 1'b1;
         busy_q       <= 1'b0;
         err_q        <= 1'b0;
         ack0_q       <= 1'b0;
         ack1_q       <= 1'b0;
      end else begin
         state_q      <= state_d;
         op_q         <= op_d;
         a_q          <= a_d;
         b_q          <= b_d;
         q_q          <= q_d;
         gnt_q        <= gnt_d;
         last_grant_q <= last_grant_d;
         busy_q       <= busy_d;
         err_q        <= err_d;
         ack0_q       <= ack0_d;
         ack1_q       <= ack1_d;
      end
   end

   assign q          = q_q;
   assign busy       = busy_q;
   assign err        = err_q;
   assign ack0       = ack0_q;
   assign ack1       = ack1_q;
   assign last_grant = last_grant_q;

endmodule

// File: tb/tb_srbank_arbiter.sv
// tb/tb_srbank_arbiter.sv - directed self-checking bench for srbank_arbiter
module tb_srbank_arbiter;

   logic       clk = 1'b0;
   logic       rst;
   logic       req0, req1;
   logic [1:0] op0, op1;
   logic [3:0] a0, b0, a1, b1;
   logic       ack0, ack1;
   logic [3:0] q;
   logic       busy, err, err_clr, last_grant;

   int checks   = 0;
   int failures = 0;

   srbank_arbiter #(.WIDTH(4)) dut (
      .clk(clk), .rst(rst),
      .req0(req0), .op0(op0), .a0(a0), .b0(b0), .ack0(ack0),
      .req1(req1), .op1(op1), .a1(a1), .b1(b1), .ack1(ack1),
      .q(q), .busy(busy), .err(err), .err_clr(err_clr), .last_grant(last_grant)
   );

   always #5 clk = ~clk;

   task automatic chk1(input string tag, input logic obs, input logic exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
      end
   endtask

   task automatic chk4(input string tag, input logic [3:0] obs, input logic [3:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
      end
   endtask

   task automatic step;
      @(posedge clk);
      #1;
   endtask

   // One full transaction; operands are scrambled after grant to prove they were captured.
   task automatic txn(input logic r, input logic [1:0] op, input logic [3:0] a, input logic [3:0] b,
                      input logic [3:0] exp_q, input logic exp_err, input logic clr_on_apply);
      if (r) begin req1 = 1'b1; op1 = op; a1 = a; b1 = b; end
      else   begin req0 = 1'b1; op0 = op; a0 = a; b0 = b; end
      step;
      chk1("grant_busy", busy, 1'b1);
      chk1("grant_last", last_grant, r);
      req0 = 1'b0; req1 = 1'b0;
      a0 = ~a0; b0 = ~b0; a1 = ~a1; b1 = ~b1; op0 = ~op0; op1 = ~op1;
      err_clr = clr_on_apply;
      step;
      err_clr = 1'b0;
      chk4("apply_q", q, exp_q);
      chk1("apply_err", err, exp_err);
      chk1("apply_ack0", ack0, 1'b0);
      chk1("apply_ack1", ack1, 1'b0);
      step;
      chk1("ack0_pulse", ack0, ~r);
      chk1("ack1_pulse", ack1, r);
      chk1("ack_busy", busy, 1'b0);
      step;
      chk1("post_ack0", ack0, 1'b0);
      chk1("post_ack1", ack1, 1'b0);
      chk1("post_busy", busy, 1'b0);
   endtask

   initial begin
      rst = 1'b1; req0 = 1'b0; req1 = 1'b0; err_clr = 1'b0;
      op0 = 2'b00; op1 = 2'b00; a0 = 4'h0; b0 = 4'h0; a1 = 4'h0; b1 = 4'h0;
      step;
      step;
      chk4("rst_q", q, 4'b0000);
      chk1("rst_ack0", ack0, 1'b0);
      chk1("rst_ack1", ack1, 1'b0);
      chk1("rst_busy", busy, 1'b0);
      chk1("rst_err", err, 1'b0);
      chk1("rst_last", last_grant, 1'b1);
      rst = 1'b0;
      step;

      // Reset asserted while a D op of 1111 is in APPLY aborts it at once.
      req0 = 1'b1; op0 = 2'b00; a0 = 4'b1111;
      step;
      chk1("abort_grant_busy", busy, 1'b1);
      req0 = 1'b0;
      #2;
      rst = 1'b1;
      #1;
      chk4("abort_q", q, 4'b0000);
      chk1("abort_busy", busy, 1'b0);
      chk1("abort_ack0", ack0, 1'b0);
      chk1("abort_err", err, 1'b0);
      step;
      chk4("abort_q_held", q, 4'b0000);
      chk1("abort_ack0_held", ack0, 1'b0);
      rst = 1'b0;
      step;

      txn(1'b0, 2'b00, 4'b1010, 4'b0000, 4'b1010, 1'b0, 1'b0);
      txn(1'b1, 2'b01, 4'b1111, 4'b0000, 4'b0101, 1'b0, 1'b0);
      txn(1'b1, 2'b01, 4'b0000, 4'b0000, 4'b0101, 1'b0, 1'b0);
      txn(1'b0, 2'b10, 4'b1000, 4'b0001, 4'b1100, 1'b0, 1'b0);
      txn(1'b0, 2'b10, 4'b1111, 4'b1111, 4'b0011, 1'b0, 1'b0);
      txn(1'b1, 2'b00, 4'b1100, 4'b0000, 4'b1100, 1'b0, 1'b0);
      txn(1'b0, 2'b11, 4'b0011, 4'b0110, 4'b1001, 1'b1, 1'b0);

      err_clr = 1'b1;
      step;
      err_clr = 1'b0;
      chk1("err_clr_alone", err, 1'b0);
      step;
      txn(1'b0, 2'b11, 4'b0011, 4'b0110, 4'b1001, 1'b1, 1'b1);

      // Both requesters held continuously: grants alternate every 3 cycles.
      rst = 1'b1;
      step;
      rst = 1'b0;
      step;
      op0 = 2'b00; a0 = 4'b0011; b0 = 4'b0000;
      op1 = 2'b00; a1 = 4'b1100; b1 = 4'b0000;
      req0 = 1'b1; req1 = 1'b1;
      for (int i = 0; i < 4; i++) begin
         step;
         chk1("rr_grant", last_grant, i[0]);
         chk1("rr_busy", busy, 1'b1);
         chk1("rr_no_ack0", ack0, 1'b0);
         chk1("rr_no_ack1", ack1, 1'b0);
         step;
         chk4("rr_q", q, i[0] ? 4'b1100 : 4'b0011);
         step;
         chk1("rr_ack0", ack0, ~i[0]);
         chk1("rr_ack1", ack1, i[0]);
         if (i == 3) begin
            req0 = 1'b0;
            req1 = 1'b0;
         end
      end
      step;
      chk1("rr_idle_busy", busy, 1'b0);
      chk1("rr_idle_ack0", ack0, 1'b0);
      chk1("rr_idle_ack1", ack1, 1'b0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
